// File: rtl/key_pkg.sv
// Shared types and constants for the key-load stage in front of the
// XOR-locked c432 core.
package key_pkg;

    localparam int KEY_WIDTH_C = 32;
    localparam int CNT_W_C = 6;
    localparam logic [KEY_WIDTH_C-1:0] DECOY_KEY_C = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        COMMIT = 3'd3,
        FAIL   = 3'd4,
        DONE   = 3'd5
    } key_ld_state_e;

endpackage

// File: rtl/key_load_ctrl_shift_reg.sv
// Serial-in/parallel-out key shadow register with running even parity.
// First bit in ends up in bit 0 after WIDTH shifts.
module key_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic             par
);

    // Shift new bits in at the top so the LSB-first stream lands in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            par  <= 1'b0;
        end else if (clr) begin
            data <= '0;
            par  <= 1'b0;
        end else if (en) begin
            data <= {din, data[WIDTH-1:1]};
            par  <= par ^ din;
        end
    end

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader: assembles a parity-protected key and commits it
// to the locked core's keyinput bus, driving a decoy until then.
module key_load_ctrl
    import key_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_C,
    parameter int CNT_W = CNT_W_C,
    parameter logic [KEY_WIDTH-1:0] DECOY_KEY = DECOY_KEY_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_WIDTH - 1);

    key_ld_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [KEY_WIDTH-1:0] shadow;
    logic shadow_par;
    logic xfer;
    logic start;
    logic shift_en;

    // Only SHIFT and PARITY consume serial bits.
    always_comb begin
        ser_ready = (state == SHIFT) || (state == PARITY);
    end

    assign xfer = ser_valid & ser_ready;
    assign start = load_start & ((state == IDLE) || (state == DONE));
    assign shift_en = xfer & (state == SHIFT);

    key_shift_reg #(
        .WIDTH(KEY_WIDTH)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (shift_en),
        .din (ser_data),
        .data(shadow),
        .par (shadow_par)
    );

    // Load sequencer with the held key output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_out   <= DECOY_KEY;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (cnt == LAST) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (xfer) begin
                        state <= (shadow_par ^ ser_data) ? FAIL : COMMIT;
                    end
                end
                COMMIT: begin
                    key_out   <= shadow;
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                FAIL: begin
                    key_out   <= DECOY_KEY;
                    key_valid <= 1'b0;
                    err       <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
- Sequential key-provisioning stage directly upstream of the XOR-locked c432 netlist (32 key inputs, keyinput0..keyinput31).
- Receives a key serially from a key store or scan port over a valid/ready bit stream, assembles it, and checks an even-parity bit.
- Commits the key to a held output register that drives the locked core's keyinput bus; until a good key is committed, the register drives a decoy key.

Parameters:
- KEY_WIDTH, 32, number of key bits; equals the key-input count of the locked core.
- CNT_W, 6, bit counter width; must satisfy 2**CNT_W > KEY_WIDTH.
- DECOY_KEY, 32'h0000_0000, value driven on key_out while no valid key is committed.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous active-high reset.
- load_start  input  1  one-cycle pulse that begins a key load.
- ser_valid  input  1  a serial bit is offered on ser_data.
- ser_data  input  1  serial key bit; LSB (keyinput0) first, then one parity bit.
- ser_ready  output  1  the block accepts a bit this cycle.
- key_out  output  KEY_WIDTH  key bus; bit i drives keyinput<i> of the locked core.
- key_valid  output  1  key_out holds a parity-checked committed key.
- busy  output  1  a load is in progress.
- err  output  1  the last load failed the parity check; sticky until the next load_start.

Behaviour:
- Reset is asynchronous, active-high: key_out=DECOY_KEY, key_valid=0, busy=0, err=0, ser_ready=0, state=IDLE, counter=0, shift register=0.
- Registered outputs: key_out, key_valid, err, busy.
- ser_ready is combinational from state: 1 only in SHIFT and PARITY.
- States:
  - IDLE: ser_ready=0. load_start -> SHIFT; that edge sets busy=1, clears err, counter=0.
  - SHIFT: a transfer occurs when ser_valid & ser_ready. Shift ser_data into shadow bit[counter], counter+1, and accumulate XOR parity. When counter reaches KEY_WIDTH-1 and that bit transfers -> PARITY.
  - PARITY: on transfer, form the parity of data XOR ser_data.
    - Result 0 -> COMMIT.
    - Result 1 -> FAIL.
  - COMMIT (1 cycle): key_out<=shadow, key_valid<=1, busy<=0 -> DONE.
  - FAIL (1 cycle): key_out<=DECOY_KEY, key_valid<=0, err<=1, busy<=0 -> IDLE.
  - DONE: behaves as IDLE but key_valid=1. load_start -> SHIFT.
- Reload from DONE: key_out and key_valid keep the old key until the new COMMIT or FAIL. The locked core never sees a partially shifted key.
- load_start while busy (SHIFT or PARITY) is ignored. The load continues and no restart occurs.
- ser_valid=0 stalls: no state or counter change, unbounded wait. No timeout.
- ser_valid while ser_ready=0 is ignored; the bit is not consumed.
- Latency: a load needs KEY_WIDTH+1 transfers. With ser_valid held high from the cycle after load_start, key_out and key_valid update on the clock edge KEY_WIDTH+2 cycles after the load_start edge, i.e. 34 for KEY_WIDTH=32.
- Shadow register: never visible on key_out except through COMMIT. It is cleared to 0 on entry to SHIFT.
- Reset mid-load: immediate return to the reset values. key_out reverts to DECOY_KEY and key_valid drops asynchronously.
- Counter never wraps: the SHIFT -> PARITY transition takes priority at count KEY_WIDTH-1.

Decomposition:
- Shared package key_pkg:
  - state enum key_ld_state_e {IDLE, SHIFT, PARITY, COMMIT, FAIL, DONE}.
  - Constant KEY_WIDTH_C=32, matching the locked core.
  - Constant DECOY_KEY_C.
- One natural sub-module, key_shift_reg: a KEY_WIDTH serial-in/parallel-out register with enable, clear and a running-parity output.
- The FSM and output register stay in key_load_ctrl.

Test Plan:
- Reset, then idle 10 cycles -> key_out=32'h0, key_valid=0, err=0, ser_ready=0, busy=0.
- load_start, stream key 32'hA5C3_0F96 LSB first, then parity bit 0 (popcount 16, even), ser_valid held high -> on the 34th edge key_out=32'hA5C3_0F96, key_valid=1, busy=0, err=0.
- Same key with parity bit 1 -> key_out=32'h0, key_valid=0, err=1. A following good load of 32'h0000_0001 with parity 1 clears err and commits 32'h0000_0001.
- Committed 32'hFFFF_FFFF; reload 32'h1234_5678 (popcount 13, parity 1) with ser_valid toggling every other cycle, plus an extra load_start mid-stream -> key_out stays 32'hFFFF_FFFF until commit. The extra pulse is ignored and the final key_out is 32'h1234_5678.
- Assert rst after 20 bits of a load -> key_out=32'h0, key_valid=0, busy=0 immediately. A new load of 32'hDEAD_BEEF (popcount 24, parity 0) then commits correctly.
- Connect key_out to the locked c432 with the correct key; compare G223..G432 against the unlocked c432 over 1000 random input vectors -> zero mismatches. With key_valid=0 the bench records the mismatch rate for DECOY_KEY.
